ram_io_responder: RTL and testbench
===================================

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 17; RAM byte-address width, giving 128 KB.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16; depth of each byte FIFO; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit; the single clock.
REQ-004 SHALL have port rst, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port mem_a, input, 32 bits; CPU byte address.
REQ-006 SHALL have port mem_dout, input, 8 bits; CPU write data.
REQ-007 SHALL have port mem_wr, input, 1 bit; 1 = write, 0 = read.
REQ-008 SHALL have port mem_din, output, 8 bits; read data to the CPU.
REQ-009 SHALL have port rdy, output, 1 bit; CPU run enable.
REQ-010 SHALL have ports rx_valid (input, 1), rx_data (input, 8) and rx_ready (output, 1); input byte stream.
REQ-011 SHALL have ports tx_valid (output, 1), tx_data (output, 8) and tx_ready (input, 1); output byte stream.
REQ-012 SHALL have port prog_stop, output, 1 bit; sticky program-end flag.

Function
REQ-013 SHALL decode mem_a[17]=0 as RAM at mem_a[RAM_AW-1:0] and mem_a[17]=1 as I/O; I/O uses mem_a[2:0] only.
REQ-014 SHALL drive rdy = (tx FIFO count < FIFO_DEPTH) AND NOT prog_stop, combinationally.
REQ-015 SHALL ignore the CPU bus completely in any cycle with rdy=0: no write, no FIFO pop, no counter latch, read pipeline frozen.
REQ-016 SHALL write mem_dout into RAM at the clock edge ending a cycle with rdy=1, mem_wr=1 and mem_a[17]=0 (1-cycle write).
REQ-017 SHALL give reads a 2-cycle latency: address and read type sampled at edge k, data registered at edge k+1, and mem_din holding that data from edge k+2 until the next advancing edge.
REQ-018 SHALL make mem_din for a read of 0x30000 the rx FIFO head; the pop occurs at the sampling edge; an empty FIFO returns 0x00 with no pop.
REQ-019 SHALL keep a 32-bit cycle counter that increments on every edge with rdy=1 and wraps from 0xFFFFFFFF to 0.
REQ-020 SHALL latch a counter snapshot on a read of 0x30004; reads of 0x30004..0x30007 return snapshot bytes 0..3, little-endian.
REQ-021 SHALL, on a write to 0x30000 with mem_dout≠0x00, push mem_dout into the tx FIFO; a write of 0x00 is ignored.
REQ-022 SHALL, on a write to 0x30004, push 0x00 into the tx FIFO and set prog_stop; prog_stop clears only on reset.
REQ-023 SHALL treat reads and writes of other I/O offsets as no-ops, with reads returning 0x00.
REQ-024 SHALL drive tx_valid = tx FIFO not empty and tx_data = tx FIFO head; the FIFO pops on tx_valid AND tx_ready.
REQ-025 SHALL drive rx_ready = rx FIFO not full; the FIFO pushes on rx_valid AND rx_ready.
REQ-026 SHALL allow a simultaneous push and pop on a non-empty FIFO, leaving the count unchanged; a push into a full FIFO cannot occur.
REQ-027 SHALL, with rdy low and prog_stop set, keep draining the tx FIFO, so the final 0x00 is still emitted.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear both FIFOs (pointers and counts), the counter, the snapshot, prog_stop, the read pipeline and mem_din to 0.
REQ-029 SHALL hold rdy=1, rx_ready=1 and tx_valid=0 out of reset; RAM contents are not cleared.
REQ-030 SHALL abandon any in-flight read on reset mid-operation; its data never appears on mem_din.

Structure
REQ-031 SHALL take IO_BASE=0x30000, IO_CLK=0x30004, the I/O select bit index 17 and the default FIFO_DEPTH from a shared package.
REQ-032 SHALL implement both streams with one sub-module, byte_fifo (parameterised depth, valid/ready both sides, count output), instantiated twice.
REQ-033 SHALL implement the RAM as an inferred synchronous-read byte array inside this block.

Verification
REQ-034 SHALL test RAM round trip: write 0xA5 @0x00010; read 0x00010 at edge k -> mem_din=0xA5 from edge k+2.
REQ-035 SHALL test rx input: push 0x41, 0x42; read 0x30000 twice -> 0x41 then 0x42; a third read -> 0x00.
REQ-036 SHALL test tx output: write 0x48, 0x00, 0x49 to 0x30000 with tx_ready=1 -> tx stream 0x48, 0x49 only.
REQ-037 SHALL test tx backpressure: tx_ready=0 and FIFO_DEPTH writes -> rdy=0; a further bus write is ignored; one tx_ready pulse -> rdy=1 and count FIFO_DEPTH-1.
REQ-038 SHALL test the clock: after N rdy-high cycles, reads of 0x30004..0x30007 -> snapshot equals N (±pipeline offset fixed by REQ-020), bytes little-endian.
REQ-039 SHALL test stop: write 0x30004 -> prog_stop=1, rdy=0, tx emits 0x00; assert rst=0 mid-read -> mem_din=0 and prog_stop=0.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// Shared constants and types for the RAM / byte-stream I/O responder.
package ram_io_responder_pkg;

  localparam logic [31:0] IO_BASE            = 32'h0003_0000;
  localparam logic [31:0] IO_CLK             = 32'h0003_0004;
  localparam int unsigned IO_SEL_BIT         = 17;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

  // I/O registers are decoded from the low three address bits only.
  localparam logic [2:0] IO_OFF_DATA = IO_BASE[2:0];
  localparam logic [2:0] IO_OFF_CLK  = IO_CLK[2:0];

  // Kind of access travelling down the read pipeline.
  typedef enum logic [1:0] {
    RdNone,
    RdRam,
    RdIo
  } rd_kind_e;

  // Little-endian byte lane of a 32-bit snapshot.
  function automatic logic [7:0] snap_byte(input logic [31:0] snap, input logic [1:0] lane);
    return snap[8*lane +: 8];
  endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with valid/ready on both sides and an occupancy count.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [7:0]             i_data,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [7:0]             o_data,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned    PW         = $clog2(DEPTH);
  localparam logic [PW:0]    COUNT_FULL = (PW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_ready = (r_count != COUNT_FULL);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Storage: not reset, the pointers and count decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// CPU-side responder: byte RAM plus memory-mapped rx/tx byte streams, cycle counter and stop flag.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        rdy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] TX_FULL = CW'(FIFO_DEPTH);

  // Bus decode
  logic              w_rdy;
  logic              w_is_io;
  logic [2:0]        w_off;
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_bus_wr;
  logic              w_ram_we;
  logic              w_wr_char;
  logic              w_wr_stop;
  logic              w_rd_io;
  logic              w_snap_latch;
  rd_kind_e          w_rd_kind;
  logic              w_unused_addr;

  // Streams
  logic [CW-1:0]     w_tx_count;
  logic              w_tx_push;
  logic [7:0]        w_tx_wdata;
  logic              w_unused_tx_in_ready;
  logic              w_rx_avail;
  logic [7:0]        w_rx_head;
  logic              w_rx_pop;
  logic [CW-1:0]     w_unused_rx_count;

  // State
  logic [7:0]        r_ram [2**RAM_AW];
  logic [7:0]        r_ram_rdata;
  logic [31:0]       r_cycles;
  logic [31:0]       r_snap;
  logic              r_prog_stop;
  rd_kind_e          r_s1_kind;
  logic [RAM_AW-1:0] r_s1_addr;
  logic [2:0]        r_s1_off;
  logic [7:0]        r_s1_rx;
  rd_kind_e          r_s2_kind;
  logic [7:0]        r_s2_io;
  logic [7:0]        r_mem_din;
  logic [7:0]        w_s1_io_byte;

  // The CPU only advances while the tx FIFO has room and the program has not ended.
  assign w_rdy         = (w_tx_count < TX_FULL) & ~r_prog_stop;
  assign w_is_io       = mem_a[IO_SEL_BIT];
  assign w_off         = mem_a[2:0];
  assign w_ram_addr    = mem_a[RAM_AW-1:0];
  assign w_unused_addr = ^mem_a;

  assign w_bus_wr     = w_rdy & mem_wr;
  assign w_ram_we     = w_bus_wr & ~w_is_io;
  assign w_wr_char    = w_bus_wr & w_is_io & (w_off == IO_OFF_DATA) & (mem_dout != 8'h00);
  assign w_wr_stop    = w_bus_wr & w_is_io & (w_off == IO_OFF_CLK);
  assign w_rd_io      = w_rdy & ~mem_wr & w_is_io;
  assign w_rx_pop     = w_rd_io & (w_off == IO_OFF_DATA) & w_rx_avail;
  assign w_snap_latch = w_rd_io & (w_off == IO_OFF_CLK);

  // The stop write queues a final 0x00 so the consumer sees the end of output.
  assign w_tx_push  = w_wr_char | w_wr_stop;
  assign w_tx_wdata = w_wr_stop ? 8'h00 : mem_dout;

  assign rdy       = w_rdy;
  assign mem_din   = r_mem_din;
  assign prog_stop = r_prog_stop;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_valid(w_tx_push),
    .i_data (w_tx_wdata),
    .o_ready(w_unused_tx_in_ready),
    .o_valid(tx_valid),
    .o_data (tx_data),
    .i_ready(tx_ready),
    .o_count(w_tx_count)
  );

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_valid(rx_valid),
    .i_data (rx_data),
    .o_ready(rx_ready),
    .o_valid(w_rx_avail),
    .o_data (w_rx_head),
    .i_ready(w_rx_pop),
    .o_count(w_unused_rx_count)
  );

  // Classify the access being sampled this cycle; nothing enters the pipeline while stalled.
  always_comb begin
    w_rd_kind = RdNone;
    if (w_rdy && !mem_wr) w_rd_kind = w_is_io ? RdIo : RdRam;
  end

  // Resolve an I/O read: rx byte captured at sampling, offsets 4..7 select snapshot lanes.
  always_comb begin
    w_s1_io_byte = 8'h00;
    if (r_s1_kind == RdIo) begin
      if (r_s1_off == IO_OFF_DATA) w_s1_io_byte = r_s1_rx;
      else if (r_s1_off[2]) w_s1_io_byte = snap_byte(r_snap, r_s1_off[1:0]);
    end
  end

  // RAM: bus write port and synchronous read of the address sampled one edge earlier.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr] <= mem_dout;
    if (w_rdy) r_ram_rdata <= r_ram[r_s1_addr];
  end

  // Cycle counter, snapshot latch and sticky program-end flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles    <= '0;
      r_snap      <= '0;
      r_prog_stop <= 1'b0;
    end else begin
      if (w_rdy) r_cycles <= r_cycles + 32'd1;
      if (w_snap_latch) r_snap <= r_cycles;
      if (w_wr_stop) r_prog_stop <= 1'b1;
    end
  end

  // Read pipeline: sample (k), resolve (k+1), present on mem_din (k+2); frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_kind <= RdNone;
      r_s1_addr <= '0;
      r_s1_off  <= '0;
      r_s1_rx   <= '0;
      r_s2_kind <= RdNone;
      r_s2_io   <= '0;
      r_mem_din <= '0;
    end else if (w_rdy) begin
      r_s1_kind <= w_rd_kind;
      r_s1_addr <= w_ram_addr;
      r_s1_off  <= w_off;
      r_s1_rx   <= w_rx_pop ? w_rx_head : 8'h00;
      r_s2_kind <= r_s1_kind;
      r_s2_io   <= w_s1_io_byte;
      r_mem_din <= (r_s2_kind == RdRam) ? r_ram_rdata : r_s2_io;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: read scoreboard plus tx stream capture.
module tb_ram_io_responder;
  import ram_io_responder_pkg::*;

  localparam int unsigned DEPTH = DEFAULT_FIFO_DEPTH;

  logic        clk;
  logic        rst;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        rdy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t    sb_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] tx_seen[$];
  int         n_total;
  int         n_pass;

  ram_io_responder #(
    .RAM_AW    (17),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .rdy      (rdy),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .prog_stop(prog_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every tx handshake mid-cycle, while inputs are stable.
  always @(negedge clk) begin
    if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) tx_seen.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = w;
    mem_dout = d;
  endtask

  // Idle bus: a read of an unused I/O offset, which has no side effects.
  task automatic idle();
    drive(32'h0003_0001, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    sb_q.delete();
    tx_exp.delete();
    tx_seen.delete();
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    idle();
    tick();
    n_total++; if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy); else n_pass++;
    n_total++;
    if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", rx_ready);
    else n_pass++;
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    else n_pass++;
    n_total++;
    if (mem_din !== 8'h00) $display("FAIL reset_mem_din: got %h want 00", mem_din);
    else n_pass++;
    n_total++;
    if (prog_stop !== 1'b0) $display("FAIL reset_prog_stop: got %b want 0", prog_stop);
    else n_pass++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] a[7] = '{32'h10, 32'h1FFFF, 32'h10, 32'h1FFFF, 32'h30002, 32'h30003, 32'h10};
    logic        w[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  d[7] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00};
    logic [7:0]  e[7] = '{8'h00, 8'h00, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'hA5};
    rd_exp_t     r;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      if (j < 7) begin
        drive(a[j], w[j], d[j]);
        sb_q.push_back('{chk: !w[j], exp: e[j]});
      end else begin
        idle();
        sb_q.push_back('{chk: 1'b1, exp: 8'h00});
      end
      tick();
      if (j >= 2) begin
        r = sb_q.pop_front();
        if (r.chk) begin
          n_total++;
          if (mem_din !== r.exp) $display("FAIL ram_read[%0d]: got %h want %h", j - 2, mem_din, r.exp);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL io_noop_write: tx_valid %b want 0", tx_valid);
    else n_pass++;
  endtask

  task automatic test_rx();
    logic [7:0] e[3] = '{8'h41, 8'h42, 8'h00};
    rd_exp_t    r;
    do_reset();
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    tick();
    rx_data = 8'h42;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    n_total++;
    if (rx_ready !== 1'b1) $display("FAIL rx_ready_partial: got %b want 1", rx_ready);
    else n_pass++;
    for (int j = 0; j < 5; j++) begin
      if (j < 3) begin
        drive(32'h0003_0000, 1'b0, 8'h00);
        sb_q.push_back('{chk: 1'b1, exp: e[j]});
      end else begin
        idle();
        sb_q.push_back('{chk: 1'b1, exp: 8'h00});
      end
      tick();
      if (j >= 2) begin
        r = sb_q.pop_front();
        n_total++;
        if (mem_din !== r.exp) $display("FAIL rx_read[%0d]: got %h want %h", j - 2, mem_din, r.exp);
        else n_pass++;
      end
    end
    // Fill the rx FIFO to capacity, then free one slot with a bus read.
    idle();
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'(8'h10 + i);
      tick();
    end
    rx_valid = 1'b0;
    n_total++;
    if (rx_ready !== 1'b0) $display("FAIL rx_full_ready: got %b want 0", rx_ready);
    else n_pass++;
    drive(32'h0003_0000, 1'b0, 8'h00);
    tick();
    idle();
    n_total++;
    if (rx_ready !== 1'b1) $display("FAIL rx_after_pop_ready: got %b want 1", rx_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (mem_din !== 8'h10) $display("FAIL rx_full_head: got %h want 10", mem_din);
    else n_pass++;
  endtask

  task automatic test_tx();
    logic [7:0] d[3] = '{8'h48, 8'h00, 8'h49};
    logic [7:0] exp_b;
    logic [7:0] got_b;
    do_reset();
    tx_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(32'h0003_0000, 1'b1, d[j]);
      if (d[j] != 8'h00) tx_exp.push_back(d[j]);
      tick();
    end
    idle();
    repeat (4) tick();
    n_total++;
    if (tx_seen.size() !== tx_exp.size())
      $display("FAIL tx_count: got %0d want %0d", tx_seen.size(), tx_exp.size());
    else n_pass++;
    while (tx_exp.size() != 0 && tx_seen.size() != 0) begin
      exp_b = tx_exp.pop_front();
      got_b = tx_seen.pop_front();
      n_total++;
      if (got_b !== exp_b) $display("FAIL tx_byte: got %h want %h", got_b, exp_b);
      else n_pass++;
    end
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL tx_drained: tx_valid %b want 0", tx_valid);
    else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b;
    logic [7:0] got_b;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(i + 1));
      tx_exp.push_back(8'(i + 1));
      tick();
    end
    n_total++; if (rdy !== 1'b0) $display("FAIL bp_full_rdy: got %b want 0", rdy); else n_pass++;
    drive(32'h0003_0000, 1'b1, 8'h77);
    repeat (3) tick();
    n_total++; if (rdy !== 1'b0) $display("FAIL bp_stall_rdy: got %b want 0", rdy); else n_pass++;
    n_total++;
    if (tx_data !== 8'h01) $display("FAIL bp_head: got %h want 01", tx_data);
    else n_pass++;
    idle();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_total++; if (rdy !== 1'b1) $display("FAIL bp_pulse_rdy: got %b want 1", rdy); else n_pass++;
    n_total++;
    if (tx_seen.size() !== 1) $display("FAIL bp_pulse_pops: got %0d want 1", tx_seen.size());
    else n_pass++;
    tx_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    tx_ready = 1'b0;
    n_total++;
    if (tx_seen.size() !== DEPTH)
      $display("FAIL bp_total: got %0d want %0d", tx_seen.size(), DEPTH);
    else n_pass++;
    while (tx_exp.size() != 0 && tx_seen.size() != 0) begin
      exp_b = tx_exp.pop_front();
      got_b = tx_seen.pop_front();
      n_total++;
      if (got_b !== exp_b) $display("FAIL bp_byte: got %h want %h", got_b, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_clock();
    logic [31:0] n_cyc = 32'd300;
    logic [7:0]  e[4];
    rd_exp_t     r;
    for (int i = 0; i < 4; i++) e[i] = n_cyc[8*i +: 8];
    do_reset();
    repeat (300) tick();
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        drive(32'h0003_0004 + 32'(j), 1'b0, 8'h00);
        sb_q.push_back('{chk: 1'b1, exp: e[j]});
      end else begin
        idle();
        sb_q.push_back('{chk: 1'b1, exp: 8'h00});
      end
      tick();
      if (j >= 2) begin
        r = sb_q.pop_front();
        n_total++;
        if (mem_din !== r.exp) $display("FAIL clk_byte[%0d]: got %h want %h", j - 2, mem_din, r.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stop();
    do_reset();
    tx_ready = 1'b0;
    // Two RAM reads in flight (0xA5 from test_ram), then the stop write stalls the pipeline.
    drive(32'h10, 1'b0, 8'h00);
    tick();
    drive(32'h10, 1'b0, 8'h00);
    tick();
    drive(32'h0003_0004, 1'b1, 8'h00);
    tick();
    idle();
    n_total++;
    if (prog_stop !== 1'b1) $display("FAIL stop_flag: got %b want 1", prog_stop);
    else n_pass++;
    n_total++; if (rdy !== 1'b0) $display("FAIL stop_rdy: got %b want 0", rdy); else n_pass++;
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00)
      $display("FAIL stop_tx: got valid %b data %h want 1/00", tx_valid, tx_data);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (mem_din !== 8'hA5) $display("FAIL stop_frozen: got %h want a5", mem_din);
    else n_pass++;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_total++;
    if (tx_seen.size() !== 1) $display("FAIL stop_tx_count: got %0d want 1", tx_seen.size());
    else n_pass++;
    if (tx_seen.size() != 0) begin
      n_total++;
      if (tx_seen[0] !== 8'h00) $display("FAIL stop_tx_byte: got %h want 00", tx_seen[0]);
      else n_pass++;
    end
    n_total++;
    if (tx_valid !== 1'b0) $display("FAIL stop_tx_empty: got %b want 0", tx_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (mem_din !== 8'h00) $display("FAIL rst_mid_mem_din: got %h want 00", mem_din);
    else n_pass++;
    n_total++;
    if (prog_stop !== 1'b0) $display("FAIL rst_mid_stop: got %b want 0", prog_stop);
    else n_pass++;
    n_total++; if (rdy !== 1'b1) $display("FAIL rst_mid_rdy: got %b want 1", rdy); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_total++;
    if (mem_din !== 8'h00) $display("FAIL rst_abandon_1: got %h want 00", mem_din);
    else n_pass++;
    repeat (2) tick();
    n_total++;
    if (mem_din !== 8'h00) $display("FAIL rst_abandon_3: got %h want 00", mem_din);
    else n_pass++;
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    mem_a    = 32'h0003_0001;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    test_reset();
    test_ram();
    test_rx();
    test_tx();
    test_backpressure();
    test_clock();
    test_stop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
